ps2_key_event_decoder: RTL and testbench
========================================

Name: ps2_key_event_decoder

Overview:
- Consumes the raw PS/2 Set-2 byte stream from the keyboard receiver top (scancode byte plus one-cycle valid strobe).
- Assembles multi-byte sequences (E0 extended prefix, F0 break prefix) into single key events.
- Tracks Shift/Caps Lock state and translates each event to ASCII.
- Buffers events in a small show-ahead FIFO for the downstream consumer (UI/display logic).

Parameters:
FIFO_DEPTH, 8, number of event entries; power of two, >= 2
FIFO_AW, 3, log2(FIFO_DEPTH); pointer width

Ports:
clk  in  1  system clock
rst  in  1  reset
code_in  in  8  received scancode byte
code_valid  in  1  code_in valid; every high cycle is one byte (upstream pulses one cycle per byte)
evt_rd  in  1  pop head event; ignored when evt_valid=0
evt_valid  out  1  FIFO non-empty
evt_code  out  8  head event: base scancode (prefixes stripped)
evt_ascii  out  8  head event: ASCII, 0x00 if unmapped
evt_break  out  1  head event: 1 = release, 0 = press
evt_ext  out  1  head event: 1 = E0-prefixed key
shift_held  out  1  left or right Shift currently down
caps_lock  out  1  Caps Lock toggle state
overflow  out  1  sticky: an event was dropped on full FIFO
fifo_count  out  FIFO_AW+1  entries held

Behaviour:
- Reset: clk; rst asynchronous, active-high.
  - On rst: prefix FSM -> IDLE; FIFO empty (count 0).
  - shift L/R bits, caps_down, caps_lock, overflow all 0.
  - evt_* outputs 0.
  - rst mid-sequence discards any pending prefix.
- Prefix FSM, states IDLE, GOT_E0, GOT_F0, GOT_E0F0; advances only on code_valid.
  - IDLE:
    - E0 -> GOT_E0; F0 -> GOT_F0.
    - 0x00, 0xAA, 0xE1, 0xFA, 0xFE, 0xFF are discarded (no event, stay IDLE).
    - Any other byte -> emit make, ext=0.
  - GOT_E0:
    - F0 -> GOT_E0F0; E0 -> stay.
    - Other -> emit make, ext=1 -> IDLE.
  - GOT_F0:
    - E0 -> GOT_E0; F0 -> stay.
    - Other -> emit break, ext=0 -> IDLE.
  - GOT_E0F0:
    - E0 -> GOT_E0; F0 -> GOT_F0.
    - Other -> emit break, ext=1 -> IDLE.
- Emit:
  - The entry {code, ascii, break, ext} is written at the same clk edge that samples code_valid.
  - evt_valid/evt_* reflect it from the next cycle (1-cycle latency) when the FIFO was empty.
- ASCII is combinational from code, ext, and modifier state *before* this event's update; identical for make and break.
  - Non-ext Set-2 US letters (e.g. 0x1C='a', 0x1A='z'): uppercase iff shift_held XOR caps_lock.
  - Digit row 0x16..0x45 ('1'..'0'): with shift_held=1, map to !@#$%^&*() instead; caps has no effect.
  - 0x29->0x20, 0x5A->0x0D (ext or not), 0x66->0x08, 0x76->0x1B, 0x0D->0x09.
  - Everything else, including all other ext codes, -> 0x00.
- Modifiers (updated at the emit edge, ext=0 only):
  - 0x12 = left shift bit, 0x59 = right shift bit: make sets, break clears.
  - 0x58 make with caps_down=0 toggles caps_lock and sets caps_down.
  - 0x58 make with caps_down=1 (typematic repeat) does not toggle.
  - 0x58 break clears caps_down.
  - Modifier keys are still enqueued as events (ascii 0x00).
- FIFO:
  - Show-ahead: evt_* always present the head entry; evt_* = 0 when empty.
  - Pop on clk edge with evt_rd & evt_valid.
  - Write when full without pop: entry dropped, overflow<=1 (cleared only by rst), count stays FIFO_DEPTH.
  - Write and pop in the same cycle when full: both accepted, count unchanged.
  - Write and pop in the same cycle when empty: write accepted, pop ignored.
  - Pointers wrap modulo FIFO_DEPTH.

Test Plan:
- Bytes 1C; F0 1C -> two events:
  - {1C, 0x61, break0, ext0}
  - {1C, 0x61, break1, ext0}
  - evt_valid rises one cycle after the 1C strobe.
- Bytes 12, 1C, F0 1C, F0 12 -> shift_held=1 between first and last event; letter events ascii 0x41; shift events ascii 0x00; shift_held=0 at end.
- Bytes 58, 58, F0 58 -> caps_lock=1, toggled once.
  - Then 12, 1C -> ascii 0x61 (shift XOR caps).
  - Then 58, F0 58 -> caps_lock=0.
- Bytes AA, FA, E0 75, E0 F0 75, E0 5A:
  - AA/FA produce nothing.
  - {75, 0x00, 0, 1}, {75, 0x00, 1, 1}, {5A, 0x0D, 0, 1}.
- FIFO_DEPTH=8, nine make bytes 0x15..0x1D, no reads -> fifo_count=8, overflow=1, ninth dropped.
  - Then write plus evt_rd in the same cycle -> count stays 8.
  - Draining returns entries in order.
- Bytes E0 F0, then rst pulse, then 75 -> single event {75, 0x00, break0, ext0}; all outputs at reset values during rst.

Source files
------------

// File: rtl/ps2_key_event_decoder.sv
// PS/2 Set-2 byte stream to key-event decoder: folds E0/F0 prefixes into events,
// tracks Shift/Caps Lock, translates to ASCII and queues events in a show-ahead FIFO.
module ps2_key_event_decoder #(
  parameter int unsigned FIFO_DEPTH = 8,
  parameter int unsigned FIFO_AW    = 3
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [7:0]         code_in,
  input  logic               code_valid,
  input  logic               evt_rd,
  output logic               evt_valid,
  output logic [7:0]         evt_code,
  output logic [7:0]         evt_ascii,
  output logic               evt_break,
  output logic               evt_ext,
  output logic               shift_held,
  output logic               caps_lock,
  output logic               overflow,
  output logic [FIFO_AW:0]   fifo_count
);

  localparam logic [FIFO_AW:0]   DEPTH_C = (FIFO_AW + 1)'(FIFO_DEPTH);
  localparam logic [FIFO_AW-1:0] PTR_ONE = FIFO_AW'(1);

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    GOT_E0   = 2'd1,
    GOT_F0   = 2'd2,
    GOT_E0F0 = 2'd3
  } state_t;

  typedef struct packed {
    logic [7:0] code;
    logic [7:0] ascii;
    logic       brk;
    logic       ext;
  } evt_t;

  // Set-2 base code to ASCII, using modifier state as it stood before this event.
  function automatic logic [7:0] ascii_of(input logic [7:0] code, input logic ext,
                                          input logic shift, input logic caps);
    logic [7:0] lower;
    logic [7:0] digit;
    logic [7:0] sym;
    logic [7:0] res;
    lower = 8'h00;
    digit = 8'h00;
    sym   = 8'h00;
    res   = 8'h00;
    case (code)
      8'h1C: lower = 8'h61;  8'h32: lower = 8'h62;  8'h21: lower = 8'h63;
      8'h23: lower = 8'h64;  8'h24: lower = 8'h65;  8'h2B: lower = 8'h66;
      8'h34: lower = 8'h67;  8'h33: lower = 8'h68;  8'h43: lower = 8'h69;
      8'h3B: lower = 8'h6A;  8'h42: lower = 8'h6B;  8'h4B: lower = 8'h6C;
      8'h3A: lower = 8'h6D;  8'h31: lower = 8'h6E;  8'h44: lower = 8'h6F;
      8'h4D: lower = 8'h70;  8'h15: lower = 8'h71;  8'h2D: lower = 8'h72;
      8'h1B: lower = 8'h73;  8'h2C: lower = 8'h74;  8'h3C: lower = 8'h75;
      8'h2A: lower = 8'h76;  8'h1D: lower = 8'h77;  8'h22: lower = 8'h78;
      8'h35: lower = 8'h79;  8'h1A: lower = 8'h7A;
      default: lower = 8'h00;
    endcase
    case (code)
      8'h16: begin digit = 8'h31; sym = 8'h21; end
      8'h1E: begin digit = 8'h32; sym = 8'h40; end
      8'h26: begin digit = 8'h33; sym = 8'h23; end
      8'h25: begin digit = 8'h34; sym = 8'h24; end
      8'h2E: begin digit = 8'h35; sym = 8'h25; end
      8'h36: begin digit = 8'h36; sym = 8'h5E; end
      8'h3D: begin digit = 8'h37; sym = 8'h26; end
      8'h3E: begin digit = 8'h38; sym = 8'h2A; end
      8'h46: begin digit = 8'h39; sym = 8'h28; end
      8'h45: begin digit = 8'h30; sym = 8'h29; end
      default: begin digit = 8'h00; sym = 8'h00; end
    endcase
    if (ext) begin
      res = (code == 8'h5A) ? 8'h0D : 8'h00;
    end else if (lower != 8'h00) begin
      res = (shift ^ caps) ? (lower & 8'hDF) : lower;
    end else if (digit != 8'h00) begin
      res = shift ? sym : digit;
    end else begin
      case (code)
        8'h29:   res = 8'h20;
        8'h5A:   res = 8'h0D;
        8'h66:   res = 8'h08;
        8'h76:   res = 8'h1B;
        8'h0D:   res = 8'h09;
        default: res = 8'h00;
      endcase
    end
    return res;
  endfunction

  state_t             state;
  logic               is_e0;
  logic               is_f0;
  logic               is_junk;
  logic               emit;
  logic               emit_brk;
  logic               emit_ext;
  logic [7:0]         emit_ascii;
  logic               shift_l;
  logic               shift_r;
  logic               caps_down;
  logic [FIFO_AW-1:0] wr_ptr;
  logic [FIFO_AW-1:0] rd_ptr;
  logic               full;
  logic               empty;
  logic               rd_en;
  logic               wr_en;
  evt_t               mem [FIFO_DEPTH];
  evt_t               head;

  // Classify the incoming byte and decide whether it completes an event.
  always_comb begin
    is_e0    = (code_in == 8'hE0);
    is_f0    = (code_in == 8'hF0);
    is_junk  = (code_in == 8'h00) || (code_in == 8'hAA) || (code_in == 8'hE1) ||
               (code_in == 8'hFA) || (code_in == 8'hFE) || (code_in == 8'hFF);
    emit     = 1'b0;
    emit_brk = 1'b0;
    emit_ext = 1'b0;
    if (code_valid && !is_e0 && !is_f0) begin
      case (state)
        IDLE:     emit = !is_junk;
        GOT_E0:   begin emit = 1'b1; emit_ext = 1'b1; end
        GOT_F0:   begin emit = 1'b1; emit_brk = 1'b1; end
        default:  begin emit = 1'b1; emit_brk = 1'b1; emit_ext = 1'b1; end
      endcase
    end
    emit_ascii = ascii_of(code_in, emit_ext, shift_held, caps_lock);
  end

  // Prefix state: E0 always arms extended; F0 arms break, keeping extended only from GOT_E0.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
    end else if (code_valid) begin
      if (is_e0) begin
        state <= GOT_E0;
      end else if (is_f0) begin
        state <= (state == GOT_E0) ? GOT_E0F0 : GOT_F0;
      end else begin
        state <= IDLE;
      end
    end
  end

  // Modifier tracking; Caps toggles only on the first make of a press.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      shift_l   <= 1'b0;
      shift_r   <= 1'b0;
      caps_down <= 1'b0;
      caps_lock <= 1'b0;
    end else if (emit && !emit_ext) begin
      case (code_in)
        8'h12: shift_l <= !emit_brk;
        8'h59: shift_r <= !emit_brk;
        8'h58: begin
          if (emit_brk) begin
            caps_down <= 1'b0;
          end else if (!caps_down) begin
            caps_lock <= !caps_lock;
            caps_down <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  assign shift_held = shift_l | shift_r;

  assign full  = (fifo_count == DEPTH_C);
  assign empty = (fifo_count == '0);
  assign rd_en = evt_rd && !empty;
  assign wr_en = emit && (!full || rd_en);

  // Storage needs no reset: the head is masked while the FIFO is empty.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem[wr_ptr] <= '{code: code_in, ascii: emit_ascii, brk: emit_brk, ext: emit_ext};
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      fifo_count <= '0;
      overflow   <= 1'b0;
    end else begin
      if (wr_en) wr_ptr <= wr_ptr + PTR_ONE;
      if (rd_en) rd_ptr <= rd_ptr + PTR_ONE;
      case ({wr_en, rd_en})
        2'b10:   fifo_count <= fifo_count + (FIFO_AW + 1)'(1);
        2'b01:   fifo_count <= fifo_count - (FIFO_AW + 1)'(1);
        default: fifo_count <= fifo_count;
      endcase
      if (emit && full && !rd_en) overflow <= 1'b1;
    end
  end

  assign head      = mem[rd_ptr];
  assign evt_valid = !empty;
  assign evt_code  = empty ? 8'h00 : head.code;
  assign evt_ascii = empty ? 8'h00 : head.ascii;
  assign evt_break = empty ? 1'b0  : head.brk;
  assign evt_ext   = empty ? 1'b0  : head.ext;

endmodule

// File: tb/tb_ps2_key_event_decoder.sv
// Scoreboard bench for ps2_key_event_decoder: directed byte sequences push expected
// events; a monitor compares each popped head entry against the queue.
module tb_ps2_key_event_decoder;

  localparam int unsigned DEPTH = 8;
  localparam int unsigned AW    = 3;

  typedef struct packed {
    logic [7:0] code;
    logic [7:0] ascii;
    logic       brk;
    logic       ext;
  } exp_t;

  logic          clk = 1'b0;
  logic          rst;
  logic [7:0]    code_in;
  logic          code_valid;
  logic          evt_rd;
  logic          evt_valid;
  logic [7:0]    evt_code;
  logic [7:0]    evt_ascii;
  logic          evt_break;
  logic          evt_ext;
  logic          shift_held;
  logic          caps_lock;
  logic          overflow;
  logic [AW:0]   fifo_count;

  exp_t sb[$];
  exp_t exp_e;
  int   n_tests = 0;
  int   n_fail  = 0;
  logic drain_en = 1'b0;
  logic man_rd   = 1'b0;
  logic mon_rd   = 1'b0;
  logic pop_now;

  assign evt_rd = mon_rd | man_rd;

  ps2_key_event_decoder #(.FIFO_DEPTH(DEPTH), .FIFO_AW(AW)) dut (
    .clk(clk), .rst(rst), .code_in(code_in), .code_valid(code_valid), .evt_rd(evt_rd),
    .evt_valid(evt_valid), .evt_code(evt_code), .evt_ascii(evt_ascii),
    .evt_break(evt_break), .evt_ext(evt_ext), .shift_held(shift_held),
    .caps_lock(caps_lock), .overflow(overflow), .fifo_count(fifo_count)
  );

  always #5 clk = ~clk;

  // Monitor: compares the head entry on every cycle it will be popped.
  initial begin
    forever begin
      @(negedge clk);
      #1;
      if (rst) begin
        mon_rd = 1'b0;
      end else begin
        pop_now = evt_valid && (drain_en || man_rd);
        mon_rd  = drain_en && evt_valid;
        if (pop_now) begin
          n_tests++;
          if (sb.size() == 0) begin
            n_fail++;
            $display("FAIL evt_unexpected: got code=%h ascii=%h brk=%b ext=%b, required no event",
                     evt_code, evt_ascii, evt_break, evt_ext);
          end else begin
            exp_e = sb.pop_front();
            if ({evt_code, evt_ascii, evt_break, evt_ext} !== exp_e) begin
              n_fail++;
              $display("FAIL evt_entry: got code=%h ascii=%h brk=%b ext=%b, required code=%h ascii=%h brk=%b ext=%b",
                       evt_code, evt_ascii, evt_break, evt_ext,
                       exp_e.code, exp_e.ascii, exp_e.brk, exp_e.ext);
            end
          end
        end
      end
    end
  end

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
    n_tests++;
    if (got !== want) begin
      n_fail++;
      $display("FAIL %s: got %0h, required %0h", name, got, want);
    end
  endtask

  task automatic push(input logic [7:0] c, input logic [7:0] a, input logic b, input logic e);
    sb.push_back('{code: c, ascii: a, brk: b, ext: e});
  endtask

  task automatic send(input logic [7:0] b);
    @(negedge clk);
    code_in    = b;
    code_valid = 1'b1;
    @(negedge clk);
    code_valid = 1'b0;
  endtask

  task automatic wait_drain();
    for (int i = 0; i < 200; i++) begin
      if (sb.size() == 0 && !evt_valid) return;
      @(negedge clk);
    end
    n_tests++;
    n_fail++;
    $display("FAIL drain_timeout: got %0d pending, required 0", sb.size());
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_evt_valid"}, 32'(evt_valid), 32'd0);
    check({tag, "_evt_fields"}, 32'({evt_code, evt_ascii, evt_break, evt_ext}), 32'd0);
    check({tag, "_fifo_count"}, 32'(fifo_count), 32'd0);
    check({tag, "_mods"}, 32'({shift_held, caps_lock, overflow}), 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, required $finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst        = 1'b1;
    code_in    = 8'h00;
    code_valid = 1'b0;
    repeat (3) @(negedge clk);
    check_reset_outputs("por");
    rst = 1'b0;

    // Plain press/release with first-event latency.
    @(negedge clk);
    check("pre_valid", 32'(evt_valid), 32'd0);
    push(8'h1C, 8'h61, 1'b0, 1'b0); send(8'h1C);
    check("lat_valid", 32'(evt_valid), 32'd1);
    check("lat_count", 32'(fifo_count), 32'd1);
    send(8'hF0);
    check("f0_no_evt", 32'(fifo_count), 32'd1);
    push(8'h1C, 8'h61, 1'b1, 1'b0); send(8'h1C);
    drain_en = 1'b1;
    wait_drain();

    // Shift held across a letter.
    push(8'h12, 8'h00, 1'b0, 1'b0); send(8'h12);
    check("shift_on", 32'(shift_held), 32'd1);
    push(8'h1C, 8'h41, 1'b0, 1'b0); send(8'h1C);
    send(8'hF0); push(8'h1C, 8'h41, 1'b1, 1'b0); send(8'h1C);
    check("shift_still", 32'(shift_held), 32'd1);
    send(8'hF0); push(8'h12, 8'h00, 1'b1, 1'b0); send(8'h12);
    check("shift_off", 32'(shift_held), 32'd0);

    // Caps Lock with typematic repeat, then shift XOR caps.
    push(8'h58, 8'h00, 1'b0, 1'b0); send(8'h58);
    push(8'h58, 8'h00, 1'b0, 1'b0); send(8'h58);
    send(8'hF0); push(8'h58, 8'h00, 1'b1, 1'b0); send(8'h58);
    check("caps_on", 32'(caps_lock), 32'd1);
    push(8'h1A, 8'h5A, 1'b0, 1'b0); send(8'h1A);
    push(8'h12, 8'h00, 1'b0, 1'b0); send(8'h12);
    push(8'h1C, 8'h61, 1'b0, 1'b0); send(8'h1C);
    push(8'h16, 8'h21, 1'b0, 1'b0); send(8'h16);
    push(8'h58, 8'h00, 1'b0, 1'b0); send(8'h58);
    send(8'hF0); push(8'h58, 8'h00, 1'b1, 1'b0); send(8'h58);
    check("caps_off", 32'(caps_lock), 32'd0);
    send(8'hF0); push(8'h12, 8'h00, 1'b1, 1'b0); send(8'h12);
    check("shift_off2", 32'(shift_held), 32'd0);

    // Discarded bytes and extended keys.
    send(8'hAA); send(8'hFA);
    send(8'hE0); push(8'h75, 8'h00, 1'b0, 1'b1); send(8'h75);
    send(8'hE0); send(8'hF0); push(8'h75, 8'h00, 1'b1, 1'b1); send(8'h75);
    send(8'hE0); push(8'h5A, 8'h0D, 1'b0, 1'b1); send(8'h5A);
    wait_drain();
    check("drain_count", 32'(fifo_count), 32'd0);

    // Overflow: nine makes into an eight-entry FIFO.
    drain_en = 1'b0;
    @(negedge clk);
    push(8'h15, 8'h71, 1'b0, 1'b0); send(8'h15);
    push(8'h16, 8'h31, 1'b0, 1'b0); send(8'h16);
    push(8'h17, 8'h00, 1'b0, 1'b0); send(8'h17);
    push(8'h18, 8'h00, 1'b0, 1'b0); send(8'h18);
    push(8'h19, 8'h00, 1'b0, 1'b0); send(8'h19);
    push(8'h1A, 8'h7A, 1'b0, 1'b0); send(8'h1A);
    push(8'h1B, 8'h73, 1'b0, 1'b0); send(8'h1B);
    check("ovf_pre", 32'(overflow), 32'd0);
    push(8'h1C, 8'h61, 1'b0, 1'b0); send(8'h1C);
    send(8'h1D);
    check("full_count", 32'(fifo_count), 32'd8);
    check("ovf_set", 32'(overflow), 32'd1);
    // Write and pop together while full.
    @(negedge clk);
    code_in = 8'h29; code_valid = 1'b1; man_rd = 1'b1;
    push(8'h29, 8'h20, 1'b0, 1'b0);
    @(negedge clk);
    code_valid = 1'b0; man_rd = 1'b0;
    check("full_wr_rd_count", 32'(fifo_count), 32'd8);
    drain_en = 1'b1;
    wait_drain();
    check("ovf_sticky", 32'(overflow), 32'd1);

    // Write and pop together while empty: pop ignored.
    drain_en = 1'b0;
    @(negedge clk);
    code_in = 8'h66; code_valid = 1'b1; man_rd = 1'b1;
    push(8'h66, 8'h08, 1'b0, 1'b0);
    @(negedge clk);
    code_valid = 1'b0; man_rd = 1'b0;
    check("empty_wr_rd_count", 32'(fifo_count), 32'd1);
    drain_en = 1'b1;
    wait_drain();

    // Reset mid-sequence flushes FIFO, modifiers and pending prefix.
    drain_en = 1'b0;
    @(negedge clk);
    send(8'h12); send(8'h1C); send(8'hE0); send(8'hF0);
    check("pre_rst_count", 32'(fifo_count), 32'd2);
    check("pre_rst_shift", 32'(shift_held), 32'd1);
    rst = 1'b1;
    #1;
    check_reset_outputs("mid");
    @(negedge clk);
    rst = 1'b0;
    drain_en = 1'b1;
    push(8'h75, 8'h00, 1'b0, 1'b0); send(8'h75);
    wait_drain();

    repeat (3) @(negedge clk);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
